// File: rtl/div_128_64.sv
// Sequential restoring divider: 2*WIDTH-bit dividend / WIDTH-bit divisor,
// one quotient bit per clock, start/done handshake with error detection.
module div_128_64 #(
  parameter int WIDTH = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [2*WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]     divisor,
  output logic                 busy,
  output logic                 done,
  output logic [WIDTH-1:0]     quotient,
  output logic [WIDTH-1:0]     remainder,
  output logic                 div_by_zero,
  output logic                 overflow
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH:0]   shift_s;
  logic             ge_s;
  logic [WIDTH-1:0] dvd_hi_s, dvd_lo_s;

  // One restoring step: shift {R,Q} left, subtract divisor when it fits.
  always_comb begin
    dvd_hi_s = dividend[2*WIDTH-1:WIDTH];
    dvd_lo_s = dividend[WIDTH-1:0];
    shift_s  = {rem_q, quo_q[WIDTH-1]};
    ge_s     = (shift_s >= {1'b0, dvs_q});
  end

  // Next-state and datapath update for IDLE/CALC/DONE.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    dbz_d   = dbz_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          dvs_d = divisor;
          cnt_d = {CW{1'b0}};
          if (divisor == {WIDTH{1'b0}}) begin
            state_d = DONE;
            done_d  = 1'b1;
            quo_d   = {WIDTH{1'b1}};
            rem_d   = dvd_lo_s;
            dbz_d   = 1'b1;
            ovf_d   = 1'b0;
          end else if (dvd_hi_s >= divisor) begin
            // Quotient would need more than WIDTH bits.
            state_d = DONE;
            done_d  = 1'b1;
            quo_d   = {WIDTH{1'b1}};
            rem_d   = {WIDTH{1'b0}};
            dbz_d   = 1'b0;
            ovf_d   = 1'b1;
          end else begin
            state_d = CALC;
            busy_d  = 1'b1;
            rem_d   = dvd_hi_s;
            quo_d   = dvd_lo_s;
            dbz_d   = 1'b0;
            ovf_d   = 1'b0;
          end
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        // The true difference is below the divisor, so WIDTH bits suffice.
        if (ge_s) begin
          rem_d = shift_s[WIDTH-1:0] - dvs_q;
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = shift_s[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          busy_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rem_q   <= {WIDTH{1'b0}};
      quo_q   <= {WIDTH{1'b0}};
      dvs_q   <= {WIDTH{1'b0}};
      cnt_q   <= {CW{1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_div_128_64.sv
// Scoreboard bench for div_128_64: reference results from plain 128-bit
// arithmetic, checked by a monitor whenever done is presented.
module tb_div_128_64;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic [127:0] dividend = 128'd0;
  logic [63:0]  divisor = 64'd0;
  logic         busy, done, div_by_zero, overflow;
  logic [63:0]  quotient, remainder;

  typedef struct packed {
    logic [63:0] q;
    logic [63:0] r;
    logic        dbz;
    logic        ovf;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;
  int   edge_cnt = 0;
  int   accept_edge = 0;

  div_128_64 #(.WIDTH(64)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend),
    .divisor(divisor), .busy(busy), .done(done), .quotient(quotient),
    .remainder(remainder), .div_by_zero(div_by_zero), .overflow(overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  function automatic exp_t model(input logic [127:0] n, input logic [63:0] d);
    exp_t e;
    e = '0;
    if (d == 64'd0) begin
      e.q = '1; e.r = n[63:0]; e.dbz = 1'b1;
    end else if (n[127:64] >= d) begin
      e.q = '1; e.r = 64'd0; e.ovf = 1'b1;
    end else begin
      e.q = 64'(n / {64'd0, d});
      e.r = 64'(n % {64'd0, d});
    end
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Monitor: every done pulse consumes one scoreboard entry.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL spurious_done: got done=1 expected no pending result");
      end else begin
        mon_e = exp_q.pop_front();
        chk("quotient", quotient, mon_e.q);
        chk("remainder", remainder, mon_e.r);
        chk("div_by_zero", 64'(div_by_zero), 64'(mon_e.dbz));
        chk("overflow", 64'(overflow), 64'(mon_e.ovf));
      end
    end
  end

  task automatic start_op(input logic [127:0] n, input logic [63:0] d);
    dividend = n;
    divisor  = d;
    start    = 1'b1;
    exp_q.push_back(model(n, d));
    @(posedge clk); #1;
    accept_edge = edge_cnt;
    start    = 1'b0;
    dividend = {$urandom, $urandom, $urandom, $urandom};
    divisor  = {$urandom, $urandom};
  endtask

  task automatic wait_done(input int exp_lat, input int exp_busy, input bit chk_busy);
    int nb = 0;
    int guard = 0;
    while (!done && guard < 200) begin
      if (busy) nb++;
      @(posedge clk); #1;
      guard++;
      dividend = {$urandom, $urandom, $urandom, $urandom};
      divisor  = {$urandom, $urandom};
    end
    if (!done) begin
      tests++; fails++;
      $display("FAIL done_timeout: got no done after %0d cycles expected latency %0d", guard, exp_lat);
      if (exp_q.size() != 0) void'(exp_q.pop_front());
    end else begin
      chk("latency", 64'(edge_cnt - accept_edge + 1), 64'(exp_lat));
      if (chk_busy) chk("busy_cycles", 64'(nb), 64'(exp_busy));
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_quotient"}, quotient, 64'd0);
    chk({tag, "_remainder"}, remainder, 64'd0);
    chk({tag, "_dbz"}, 64'(div_by_zero), 64'd0);
    chk({tag, "_ovf"}, 64'(overflow), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] n;
    logic [63:0]  d, hi;
    int           kind, lat;

    #1 rst_n = 1'b0;
    #11;
    chk_all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 100 / 7 with hold check through IDLE
    start_op(128'd100, 64'd7);
    wait_done(65, 64, 1'b1);
    repeat (3) begin @(posedge clk); #1; end
    chk("hold_quotient", quotient, 64'd14);
    chk("hold_remainder", remainder, 64'd2);
    chk("hold_done_low", 64'(done), 64'd0);

    // Inverse of a mul_64 product
    n = 128'(64'hAAAA_AAAA_AAAA_AAAA) * 128'(64'h5555_5555_5555_5555);
    start_op(n, 64'h5555_5555_5555_5555);
    wait_done(65, 64, 1'b1);

    // Largest legal quotient
    start_op(128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001, 64'hFFFF_FFFF_FFFF_FFFF);
    wait_done(65, 64, 1'b1);

    // Error paths
    start_op(128'h5, 64'd0);
    wait_done(1, 0, 1'b1);
    start_op(128'h1_0000_0000_0000_0000, 64'd1);
    wait_done(1, 0, 1'b1);

    // start during CALC is ignored; start in the done cycle is accepted
    start_op(128'd100, 64'd7);
    repeat (9) begin @(posedge clk); #1; end
    start = 1'b1; dividend = 128'd200; divisor = 64'd7;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(65, 0, 1'b0);
    start_op(128'd200, 64'd7);
    wait_done(65, 64, 1'b1);

    // Reset in the middle of an operation
    @(posedge clk); #1;
    start_op(128'd100, 64'd7);
    repeat (29) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    void'(exp_q.pop_back());
    @(posedge clk); #1;
    chk_all_zero("midreset_hold");
    rst_n = 1'b1;
    @(posedge clk); #1;
    start_op(128'd100, 64'd7);
    wait_done(65, 64, 1'b1);

    // Randomised operations
    for (int i = 0; i < 30; i++) begin
      kind = $urandom_range(0, 9);
      if (kind == 0) begin
        d = 64'd0;
        n = {$urandom, $urandom, $urandom, $urandom};
      end else if (kind == 1) begin
        d = {$urandom, $urandom};
        if (d == 64'd0) d = 64'd3;
        hi = d + 64'($urandom_range(0, 5));
        if (hi < d) hi = '1;
        n = {hi, $urandom, $urandom};
      end else begin
        if (kind == 2) d = 64'($urandom_range(1, 255));
        else d = {$urandom, $urandom};
        if (d == 64'd0) d = 64'd1;
        hi = {$urandom, $urandom};
        hi = hi % d;
        n = {hi, $urandom, $urandom};
      end
      lat = (d == 64'd0 || n[127:64] >= d) ? 1 : 65;
      start_op(n, d);
      wait_done(lat, (lat == 65) ? 64 : 0, 1'b1);
      if ($urandom_range(0, 1) == 1) begin
        repeat (2) begin @(posedge clk); #1; end
      end
    end

    repeat (3) begin @(posedge clk); #1; end
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
